// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master/slave subsystem.
package apb_pkg;

  localparam int ADDR_WIDTH  = 9;
  localparam int DATA_WIDTH  = 8;
  localparam int SLV_SEL_BIT = 8;
  localparam int MEM_DEPTH   = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave.sv
// APB slave memory: 256 x 8 storage with per-location valid bits and
// programmable wait states; unwritten locations answer reads with an error.
module apb_slave
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic                    i_pclk,
  input  logic                    i_presetn,
  input  logic                    i_psel,
  input  logic                    i_penable,
  input  logic                    i_pwrite,
  input  logic [SLV_SEL_BIT-1:0]  i_paddr,
  input  logic [DATA_WIDTH-1:0]   i_pwdata,
  output logic                    o_pready,
  output logic [DATA_WIDTH-1:0]   o_prdata,
  output logic                    o_pslverr
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [MEM_DEPTH-1:0]  r_valid;
  logic [1:0]            r_wait_cnt;
  logic                  w_access;
  logic                  w_complete;
  logic                  w_hit;

  assign w_access   = i_psel & i_penable;
  assign o_pready   = w_access & (r_wait_cnt == 2'(WAIT_STATES));
  assign w_complete = o_pready;
  assign w_hit      = r_valid[i_paddr];

  // Counts ACCESS cycles already spent with PREADY low.
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_wait_cnt <= 2'd0;
    end else if (w_complete) begin
      r_wait_cnt <= 2'd0;
    end else if (w_access) begin
      r_wait_cnt <= r_wait_cnt + 2'd1;
    end
  end

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_valid <= '0;
    end else if (w_complete && i_pwrite) begin
      r_valid[i_paddr] <= 1'b1;
    end
  end

  // Storage itself is never reset; only the valid bits are.
  always_ff @(posedge i_pclk) begin
    if (w_complete && i_pwrite) begin
      r_mem[i_paddr] <= i_pwdata;
    end
  end

  assign o_prdata  = (w_access && !i_pwrite && w_hit) ? r_mem[i_paddr] : '0;
  assign o_pslverr = w_access & ~i_pwrite & ~w_hit;

endmodule

// File: rtl/apb_modport.sv
// APB subsystem top: APB3 master FSM fed by user commands, two decoded
// slave memories, and registered read-data / error outputs.
module apb_modport
  import apb_pkg::SLV_SEL_BIT, apb_pkg::IDLE, apb_pkg::SETUP, apb_pkg::ACCESS;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [ADDR_WIDTH-1:0] apb_write_paddr,
  input  logic [ADDR_WIDTH-1:0] apb_read_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  output logic [DATA_WIDTH-1:0] apb_read_data_out,
  output logic                  PSLVERR,
  output logic [1:0]            o_state
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic                  w_load;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;

  logic                  w_psel;
  logic                  w_penable;
  logic                  w_sel1;
  logic                  w_psel0;
  logic                  w_psel1;
  logic                  w_pready0;
  logic                  w_pready1;
  logic [DATA_WIDTH-1:0] w_prdata0;
  logic [DATA_WIDTH-1:0] w_prdata1;
  logic                  w_pslverr0;
  logic                  w_pslverr1;
  logic                  w_pready;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_pslverr;
  logic                  w_complete;

  assign w_psel    = (r_state != ST_IDLE);
  assign w_penable = (r_state == ST_ACCESS);
  assign w_sel1    = r_paddr[SLV_SEL_BIT];
  assign w_psel0   = w_psel & ~w_sel1;
  assign w_psel1   = w_psel & w_sel1;

  assign w_pready   = w_sel1 ? w_pready1  : w_pready0;
  assign w_prdata   = w_sel1 ? w_prdata1  : w_prdata0;
  assign w_pslverr  = w_sel1 ? w_pslverr1 : w_pslverr0;
  assign w_complete = w_penable & w_pready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (transfer) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_pready) w_next = transfer ? ST_SETUP : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // SETUP is only ever entered from IDLE or from a completing ACCESS.
  assign w_load = (w_next == ST_SETUP);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= ST_IDLE;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_pwrite <= ~READ_WRITE;
        r_paddr  <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
        r_pwdata <= apb_write_data;
      end
    end
  end

  // Error flag follows every transfer; read data is held across writes.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      apb_read_data_out <= '0;
      PSLVERR           <= 1'b0;
    end else if (w_complete) begin
      PSLVERR <= w_pslverr;
      if (!r_pwrite) begin
        apb_read_data_out <= w_prdata;
      end
    end
  end

  assign o_state = r_state;

  apb_slave #(.WAIT_STATES(WAIT_STATES)) u_slave0 (
    .i_pclk    (PCLK),
    .i_presetn (PRESETn),
    .i_psel    (w_psel0),
    .i_penable (w_penable),
    .i_pwrite  (r_pwrite),
    .i_paddr   (r_paddr[SLV_SEL_BIT-1:0]),
    .i_pwdata  (r_pwdata),
    .o_pready  (w_pready0),
    .o_prdata  (w_prdata0),
    .o_pslverr (w_pslverr0)
  );

  apb_slave #(.WAIT_STATES(WAIT_STATES)) u_slave1 (
    .i_pclk    (PCLK),
    .i_presetn (PRESETn),
    .i_psel    (w_psel1),
    .i_penable (w_penable),
    .i_pwrite  (r_pwrite),
    .i_paddr   (r_paddr[SLV_SEL_BIT-1:0]),
    .i_pwdata  (r_pwdata),
    .o_pready  (w_pready1),
    .o_prdata  (w_prdata1),
    .o_pslverr (w_pslverr1)
  );

endmodule

// File: tb/tb_apb_modport.sv
// Directed plus randomized bench for apb_modport against a flat memory model.
module tb_apb_modport;

  localparam int WS = 0;

  // Handshake: transfer is a level request sampled at posedge; inputs are
  // only meaningful on the edge that enters SETUP, and results appear on the
  // outputs right after the completing edge (2 + WS edges later).
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       transfer = 1'b0;
  logic       read_write = 1'b0;
  logic [8:0] wr_addr = '0;
  logic [8:0] rd_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       slverr;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  apb_modport #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .WAIT_STATES(WS)) dut (
    .PCLK              (clk),
    .PRESETn           (rst_n),
    .transfer          (transfer),
    .READ_WRITE        (read_write),
    .apb_write_paddr   (wr_addr),
    .apb_read_paddr    (rd_addr),
    .apb_write_data    (wr_data),
    .apb_read_data_out (rd_data),
    .PSLVERR           (slverr),
    .o_state           (dbg_state)
  );

  // Reference model: one flat 512-entry byte store with written flags.
  logic [7:0] m_mem   [512];
  bit         m_valid [512];
  logic [7:0] exp_rd;
  logic       exp_err;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".data"}, rd_data, exp_rd);
    chk({tag, ".err"}, {7'd0, slverr}, {7'd0, exp_err});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 512; i++) m_valid[i] = 1'b0;
    exp_rd  = 8'h00;
    exp_err = 1'b0;
  endtask

  task automatic model_apply(input bit rd, input logic [8:0] addr, input logic [7:0] data);
    if (rd) begin
      exp_rd  = m_valid[addr] ? m_mem[addr] : 8'h00;
      exp_err = !m_valid[addr];
    end else begin
      m_mem[addr]   = data;
      m_valid[addr] = 1'b1;
      exp_err       = 1'b0;
    end
  endtask

  task automatic drive_cmd(input bit rd, input logic [8:0] addr, input logic [7:0] data);
    read_write = rd;
    wr_data    = data;
    if (rd) begin
      rd_addr = addr;
      wr_addr = 9'($urandom);
    end else begin
      wr_addr = addr;
      rd_addr = 9'($urandom);
    end
  endtask

  // One isolated transfer; inputs are scrambled once latched to show they are ignored.
  task automatic xfer(input string tag, input bit rd, input logic [8:0] addr, input logic [7:0] data);
    @(negedge clk);
    transfer = 1'b1;
    drive_cmd(rd, addr, data);
    @(posedge clk);
    @(negedge clk);
    transfer   = 1'b0;
    read_write = 1'($urandom);
    wr_addr    = 9'($urandom);
    rd_addr    = 9'($urandom);
    wr_data    = 8'($urandom);
    repeat (WS) @(posedge clk);
    @(posedge clk);
    #1 check_outputs({tag, ".early"});
    @(posedge clk);
    #1 model_apply(rd, addr, data);
    check_outputs(tag);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] a;
    logic [7:0] d;
    bit         r;

    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs("reset");
    chk("reset.state", {6'd0, dbg_state}, 8'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check_outputs("idle");
    end

    xfer("wr_a5", 1'b0, 9'h012, 8'hA5);
    xfer("rd_a5", 1'b1, 9'h012, 8'h00);

    xfer("wr_s0", 1'b0, 9'h005, 8'h11);
    xfer("wr_s1", 1'b0, 9'h105, 8'h22);
    xfer("rd_s0", 1'b1, 9'h005, 8'h00);
    xfer("rd_s1", 1'b1, 9'h105, 8'h00);

    xfer("rd_uninit", 1'b1, 9'h1FF, 8'h00);
    xfer("rd_clear",  1'b1, 9'h005, 8'h00);

    // Back-to-back write then read with transfer held high.
    @(negedge clk);
    transfer = 1'b1;
    drive_cmd(1'b0, 9'h0F0, 8'h3C);
    rd_addr = 9'h0F0;
    @(posedge clk);
    @(negedge clk) read_write = 1'b1;
    repeat (WS) @(posedge clk);
    @(posedge clk);
    #1 check_outputs("b2b.early");
    @(posedge clk);
    #1 model_apply(1'b0, 9'h0F0, 8'h3C);
    check_outputs("b2b.wr");
    chk("b2b.no_idle", {6'd0, dbg_state}, 8'd1);
    @(negedge clk) transfer = 1'b0;
    repeat (WS) @(posedge clk);
    @(posedge clk);
    #1 check_outputs("b2b.rd_early");
    @(posedge clk);
    #1 model_apply(1'b1, 9'h0F0, 8'h00);
    check_outputs("b2b.rd");

    // Reset during SETUP of a write: nothing may land in memory.
    @(negedge clk);
    transfer = 1'b1;
    drive_cmd(1'b0, 9'h020, 8'h77);
    @(posedge clk);
    #2 rst_n = 1'b0;
    transfer = 1'b0;
    model_reset();
    #1 check_outputs("midrst");
    chk("midrst.state", {6'd0, dbg_state}, 8'd0);
    @(negedge clk) rst_n = 1'b1;
    xfer("midrst.rd", 1'b1, 9'h020, 8'h00);
    xfer("midrst.rd_old", 1'b1, 9'h012, 8'h00);

    // Random traffic over a small window of both slaves to get many hits.
    for (int i = 0; i < 60; i++) begin
      r = 1'($urandom_range(0, 1));
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 15))};
      d = 8'($urandom);
      xfer("rand", r, a, d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
